// File: rtl/sram_like_slave.sv
// Responder for the SRAM-like req/addr_ok/data_ok protocol: drives a 1-cycle synchronous SRAM
// and returns in-order responses after LATENCY extra cycles, with up to DEPTH outstanding.
module sram_like_slave #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned LATENCY = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned WW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   // The push cycle already counts as one elapsed cycle, so entries start one below LATENCY.
   localparam logic [WW-1:0] INIT_WAIT = (LATENCY > 0) ? WW'(LATENCY - 1) : '0;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] qcnt_q, qcnt_d;
   logic [PW-1:0] head_q, tail_q;
   logic          pend_q, pend_wr_q;
   logic [31:0]   q_data [DEPTH];
   logic [WW-1:0] q_wait [DEPTH];
   logic          accept, bypass, q_retire, push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign accept     = resetn & req & (cnt_q < CW'(DEPTH));
   assign addr_ok    = accept;
   assign sram_en    = accept;
   assign sram_addr  = {addr[31:2], 2'b00};
   assign sram_wdata = wdata;

   assign bypass   = (LATENCY == 0) && pend_q && (qcnt_q == '0);
   assign q_retire = (qcnt_q != '0) && (q_wait[head_q] == '0);
   assign push     = pend_q && !bypass;
   assign data_ok  = bypass | q_retire;

   always_comb begin
      sram_wen = 4'b0000;
      if (accept && wr) begin
         case (size)
            2'd0:    sram_wen = 4'b0001 << addr[1:0];
            2'd1:    sram_wen = 4'b0011 << addr[1:0];
            default: sram_wen = 4'b1111;
         endcase
      end
   end

   always_comb begin
      rdata = 32'h0;
      if (bypass) begin
         rdata = pend_wr_q ? 32'h0 : sram_rdata;
      end else if (q_retire) begin
         rdata = q_data[head_q];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, data_ok})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      qcnt_d = qcnt_q;
      case ({push, q_retire})
         2'b10:   qcnt_d = qcnt_q + CW'(1);
         2'b01:   qcnt_d = qcnt_q - CW'(1);
         default: qcnt_d = qcnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q     <= '0;
         qcnt_q    <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         pend_q    <= 1'b0;
         pend_wr_q <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            q_data[i] <= 32'h0;
            q_wait[i] <= '0;
         end
      end else begin
         cnt_q     <= cnt_d;
         qcnt_q    <= qcnt_d;
         pend_q    <= accept;
         pend_wr_q <= accept & wr;
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (q_wait[i] != '0) begin
               q_wait[i] <= q_wait[i] - WW'(1);
            end
         end
         if (push) begin
            q_data[tail_q] <= pend_wr_q ? 32'h0 : sram_rdata;
            q_wait[tail_q] <= INIT_WAIT;
            tail_q         <= ptr_inc(tail_q);
         end
         if (q_retire) begin
            head_q <= ptr_inc(head_q);
         end
      end
   end

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave: four instances (LATENCY 0/3/5/2, DEPTH 2), each with its
// own SRAM model whose unwritten words read back as a fixed address pattern.
module tb_sram_like_slave;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req [4];
   logic        wr [4];
   logic [1:0]  size [4];
   logic [31:0] addr [4];
   logic [31:0] wdata [4];
   logic        addr_ok [4];
   logic        data_ok [4];
   logic [31:0] rdata [4];
   logic        sram_en [4];
   logic [3:0]  sram_wen [4];
   logic [31:0] sram_addr [4];
   logic [31:0] sram_wdata [4];
   logic [31:0] sram_rdata [4];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a == 32'h1000) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 5 : 2;
      logic [31:0] mem [1024];
      logic        vld [1024];
      logic [9:0]  idx;
      logic [31:0] cur;
      logic [31:0] srd;

      sram_like_slave #(.DEPTH(2), .LATENCY(LAT)) u_dut (
         .clk        (clk),
         .resetn     (resetn),
         .req        (req[g]),
         .wr         (wr[g]),
         .size       (size[g]),
         .addr       (addr[g]),
         .wdata      (wdata[g]),
         .addr_ok    (addr_ok[g]),
         .data_ok    (data_ok[g]),
         .rdata      (rdata[g]),
         .sram_en    (sram_en[g]),
         .sram_wen   (sram_wen[g]),
         .sram_addr  (sram_addr[g]),
         .sram_wdata (sram_wdata[g]),
         .sram_rdata (srd)
      );

      assign sram_rdata[g] = srd;
      assign idx = sram_addr[g][11:2];
      assign cur = vld[idx] ? mem[idx] : pat(sram_addr[g]);

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            for (int i = 0; i < 1024; i++) vld[i] <= 1'b0;
            srd <= 32'h0;
         end else if (sram_en[g]) begin
            srd <= cur;
            if (sram_wen[g] != 4'b0000) begin
               for (int b = 0; b < 4; b++) begin
                  mem[idx][8*b +: 8] <= sram_wen[g][b] ? sram_wdata[g][8*b +: 8] : cur[8*b +: 8];
               end
               vld[idx] <= 1'b1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int g = 0; g < 4; g++) begin
         req[g] = 1'b0; wr[g] = 1'b0; size[g] = 2'd2; addr[g] = 32'h0; wdata[g] = 32'h0;
      end
      resetn = 1'b1;
      #2;
      resetn = 1'b0;
      req[0] = 1'b1;
      addr[0] = 32'h1000;
      #1;
      n_vec++;
      if (addr_ok[0] !== 1'b0) begin
         n_err++; $display("FAIL reset addr_ok: got %b want 0", addr_ok[0]);
      end
      n_vec++;
      if (data_ok[0] !== 1'b0) begin
         n_err++; $display("FAIL reset data_ok: got %b want 0", data_ok[0]);
      end
      n_vec++;
      if (rdata[0] !== 32'h0) begin
         n_err++; $display("FAIL reset rdata: got %h want 0", rdata[0]);
      end
      n_vec++;
      if (sram_en[0] !== 1'b0) begin
         n_err++; $display("FAIL reset sram_en: got %b want 0", sram_en[0]);
      end
      n_vec++;
      if (sram_wen[0] !== 4'b0000) begin
         n_err++; $display("FAIL reset sram_wen: got %b want 0000", sram_wen[0]);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0;
      #2;
      resetn = 1'b1;
      step();
   endtask

   task automatic test_single_read();
      req[0] = 1'b1; wr[0] = 1'b0; size[0] = 2'd2; addr[0] = 32'h1000;
      @(negedge clk);
      n_vec++;
      if (addr_ok[0] !== 1'b1 || sram_en[0] !== 1'b1) begin
         n_err++; $display("FAIL rd accept: addr_ok %b sram_en %b want 1 1", addr_ok[0], sram_en[0]);
      end
      n_vec++;
      if (sram_addr[0] !== 32'h1000 || sram_wen[0] !== 4'b0000) begin
         n_err++;
         $display("FAIL rd sram: addr %h wen %b want 00001000 0000", sram_addr[0], sram_wen[0]);
      end
      n_vec++;
      if (data_ok[0] !== 1'b0) begin
         n_err++; $display("FAIL rd early data_ok: got %b want 0", data_ok[0]);
      end
      step();
      req[0] = 1'b0;
      @(negedge clk);
      n_vec++;
      if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL rd resp: data_ok %b rdata %h want 1 deadbeef", data_ok[0], rdata[0]);
      end
      step();
      @(negedge clk);
      n_vec++;
      if (data_ok[0] !== 1'b0 || rdata[0] !== 32'h0) begin
         n_err++; $display("FAIL rd idle: data_ok %b rdata %h want 0 0", data_ok[0], rdata[0]);
      end
      step();
   endtask

   task automatic test_writes();
      logic [1:0]  sz [5];
      logic [31:0] ad [5];
      logic [3:0]  ew [5];
      sz = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      ad = '{32'h1003, 32'h1002, 32'h1000, 32'h1000, 32'h1001};
      ew = '{4'b1000, 4'b1100, 4'b1111, 4'b1111, 4'b0010};
      for (int i = 0; i < 5; i++) begin
         req[0] = 1'b1; wr[0] = 1'b1; size[0] = sz[i]; addr[0] = ad[i];
         wdata[0] = 32'h11223344 + 32'(i);
         @(negedge clk);
         n_vec++;
         if (addr_ok[0] !== 1'b1 || sram_wen[0] !== ew[i]) begin
            n_err++;
            $display("FAIL wr%0d wen: addr_ok %b wen %b want 1 %b", i, addr_ok[0], sram_wen[0], ew[i]);
         end
         n_vec++;
         if (sram_addr[0] !== 32'h1000 || sram_wdata[0] !== 32'h11223344 + 32'(i)) begin
            n_err++;
            $display("FAIL wr%0d addr/data: got %h %h want 00001000 %h", i, sram_addr[0],
                     sram_wdata[0], 32'h11223344 + 32'(i));
         end
         step();
         req[0] = 1'b0; wr[0] = 1'b0;
         @(negedge clk);
         n_vec++;
         if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            n_err++;
            $display("FAIL wr%0d resp: data_ok %b rdata %h want 1 0", i, data_ok[0], rdata[0]);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic        exp_dok;
      logic [31:0] exp_rd;
      for (int k = 0; k < 10; k++) begin
         req[0] = (k < 8); wr[0] = 1'b0; size[0] = 2'd2; addr[0] = 32'h1200 + 32'(4 * k);
         exp_dok = (k >= 1 && k <= 8);
         exp_rd = exp_dok ? pat(32'h1200 + 32'(4 * (k - 1))) : 32'h0;
         @(negedge clk);
         n_vec++;
         if (addr_ok[0] !== (k < 8)) begin
            n_err++; $display("FAIL b2b addr_ok k=%0d: got %b want %b", k, addr_ok[0], (k < 8));
         end
         n_vec++;
         if (data_ok[0] !== exp_dok || rdata[0] !== exp_rd) begin
            n_err++;
            $display("FAIL b2b resp k=%0d: data_ok %b rdata %h want %b %h", k, data_ok[0],
                     rdata[0], exp_dok, exp_rd);
         end
         step();
      end
      req[0] = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [10:0] exp_aok;
      logic [10:0] exp_dok;
      logic [31:0] exp_rd;
      exp_aok = 11'b00000100011;
      exp_dok = 11'b01000110000;
      for (int k = 0; k < 11; k++) begin
         req[1] = (k < 6); wr[1] = 1'b0; size[1] = 2'd2;
         addr[1] = (k == 0) ? 32'h1100 : (k == 1) ? 32'h1104 : 32'h1108;
         case (k)
            4:       exp_rd = 32'h1100EEFF;
            5:       exp_rd = 32'h1104EEFB;
            9:       exp_rd = 32'h1108EEF7;
            default: exp_rd = 32'h0;
         endcase
         @(negedge clk);
         n_vec++;
         if (addr_ok[1] !== exp_aok[k]) begin
            n_err++; $display("FAIL bp addr_ok k=%0d: got %b want %b", k, addr_ok[1], exp_aok[k]);
         end
         n_vec++;
         if (data_ok[1] !== exp_dok[k] || rdata[1] !== exp_rd) begin
            n_err++;
            $display("FAIL bp resp k=%0d: data_ok %b rdata %h want %b %h", k, data_ok[1],
                     rdata[1], exp_dok[k], exp_rd);
         end
         step();
      end
      req[1] = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 2; k++) begin
         req[2] = 1'b1; wr[2] = 1'b0; size[2] = 2'd2; addr[2] = 32'h1300 + 32'(4 * k);
         @(negedge clk);
         n_vec++;
         if (addr_ok[2] !== 1'b1) begin
            n_err++; $display("FAIL rst_mid accept k=%0d: got %b want 1", k, addr_ok[2]);
         end
         step();
      end
      req[2] = 1'b0;
      step();
      #2;
      resetn = 1'b0;
      req[2] = 1'b1;
      #1;
      n_vec++;
      if (addr_ok[2] !== 1'b0 || sram_en[2] !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid req side: addr_ok %b sram_en %b want 0 0", addr_ok[2], sram_en[2]);
      end
      n_vec++;
      if (data_ok[2] !== 1'b0 || rdata[2] !== 32'h0) begin
         n_err++;
         $display("FAIL rst_mid resp side: data_ok %b rdata %h want 0 0", data_ok[2], rdata[2]);
      end
      @(negedge clk);
      req[2] = 1'b0;
      #1;
      resetn = 1'b1;
      step();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_vec++;
         if (data_ok[2] !== 1'b0) begin
            n_err++; $display("FAIL rst_mid stale data_ok k=%0d: got %b want 0", k, data_ok[2]);
         end
         step();
      end
      req[2] = 1'b1; addr[2] = 32'h1308;
      @(negedge clk);
      n_vec++;
      if (addr_ok[2] !== 1'b1) begin
         n_err++; $display("FAIL rst_mid new accept: got %b want 1", addr_ok[2]);
      end
      step();
      req[2] = 1'b0;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         n_vec++;
         if (data_ok[2] !== (k == 6) || rdata[2] !== ((k == 6) ? 32'h1308ECF7 : 32'h0)) begin
            n_err++;
            $display("FAIL rst_mid new resp k=%0d: data_ok %b rdata %h want %b %h", k,
                     data_ok[2], rdata[2], (k == 6), (k == 6) ? 32'h1308ECF7 : 32'h0);
         end
         step();
      end
   endtask

   task automatic test_mixed();
      logic [8:0]  exp_aok;
      logic [8:0]  exp_dok;
      logic [31:0] exp_rd;
      exp_aok = 9'b000010011;
      exp_dok = 9'b010011000;
      for (int k = 0; k < 9; k++) begin
         req[3] = (k < 5); size[3] = 2'd2; wdata[3] = 32'hCAFEF00D;
         wr[3] = (k == 1);
         addr[3] = (k == 0) ? 32'h2000 : 32'h2004;
         case (k)
            3:       exp_rd = 32'h2000DFFF;
            7:       exp_rd = 32'hCAFEF00D;
            default: exp_rd = 32'h0;
         endcase
         @(negedge clk);
         n_vec++;
         if (addr_ok[3] !== exp_aok[k]) begin
            n_err++; $display("FAIL mix addr_ok k=%0d: got %b want %b", k, addr_ok[3], exp_aok[k]);
         end
         n_vec++;
         if (data_ok[3] !== exp_dok[k] || rdata[3] !== exp_rd) begin
            n_err++;
            $display("FAIL mix resp k=%0d: data_ok %b rdata %h want %b %h", k, data_ok[3],
                     rdata[3], exp_dok[k], exp_rd);
         end
         step();
      end
      req[3] = 1'b0; wr[3] = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_writes();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_mixed();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
